// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared types and constants for the decode-to-execute stage.
// Optional operand forwarding is enabled by defining ID_EX_FWD_EN.
package id_ex_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [2:0]      alu_ctrl;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            use_rs1;
        logic            use_rs2;
        logic            reg_write;
        logic            branch;
    } id_ex_entry_t;

    // True when the writeback bus carries a newer value for this source register.
    function automatic logic fwd_hit(input logic       fwd_valid,
                                     input logic [4:0] fwd_rd,
                                     input logic       use_rs,
                                     input logic [4:0] rs);
        return fwd_valid && (fwd_rd != REG_ZERO) && use_rs && (rs == fwd_rd);
    endfunction

endpackage

// File: rtl/id_ex_fwd_mux.sv
// id_ex_fwd_mux: patches the a/b operands of one entry from the writeback bus.
// Only instantiated when ID_EX_FWD_EN is defined.
module id_ex_fwd_mux
    import id_ex_pkg::*;
(
    input  id_ex_entry_t    entry_in,
    input  logic            fwd_valid,
    input  logic [4:0]      fwd_rd,
    input  logic [XLEN-1:0] fwd_data,
    output id_ex_entry_t    entry_out
);

    // Replace stale register operands with the value being written back.
    always_comb begin
        entry_out = entry_in;
        if (fwd_hit(fwd_valid, fwd_rd, entry_in.use_rs1, entry_in.rs1)) begin
            entry_out.a = fwd_data;
        end
        if (fwd_hit(fwd_valid, fwd_rd, entry_in.use_rs2, entry_in.rs2)) begin
            entry_out.b = fwd_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with a 2-entry skid buffer
// (main slot drives out_*, skid slot absorbs one extra entry so in_ready is
// registered). Define ID_EX_FWD_EN to enable writeback operand forwarding.
module id_ex_stage
    import id_ex_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_alu_ctrl,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_rd,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic            in_use_rs1,
    input  logic            in_use_rs2,
    input  logic            in_reg_write,
    input  logic            in_branch,
    input  logic            fwd_valid,
    input  logic [4:0]      fwd_rd,
    input  logic [XLEN-1:0] fwd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_alu_ctrl,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_branch
);

    id_ex_entry_t in_e, in_f, main_q, main_f, skid_q, skid_f, main_d, skid_d;
    logic         main_valid, skid_valid, in_ready_q;
    logic         main_valid_d, skid_valid_d;
    logic         accept, main_free;

    assign in_e = '{alu_ctrl:  in_alu_ctrl,
                    a:         in_a,
                    b:         in_b,
                    pc:        in_pc,
                    rd:        in_rd,
                    rs1:       in_rs1,
                    rs2:       in_rs2,
                    use_rs1:   in_use_rs1,
                    use_rs2:   in_use_rs2,
                    reg_write: in_reg_write,
                    branch:    in_branch};

`ifdef ID_EX_FWD_EN
    id_ex_fwd_mux u_fwd_in (
        .entry_in(in_e), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .entry_out(in_f)
    );
    id_ex_fwd_mux u_fwd_main (
        .entry_in(main_q), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .entry_out(main_f)
    );
    id_ex_fwd_mux u_fwd_skid (
        .entry_in(skid_q), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .entry_out(skid_f)
    );
`else
    logic unused_nofwd;

    assign in_f   = in_e;
    assign main_f = main_q;
    assign skid_f = skid_q;
    assign unused_nofwd = ^{fwd_valid, fwd_rd, fwd_data, main_q.rs1, main_q.rs2,
                            main_q.use_rs1, main_q.use_rs2};
`endif

    assign accept    = in_valid && in_ready_q;
    assign main_free = !main_valid || out_ready;

    // Slot steering: skid drains into main first, so a same-cycle accept queues behind it.
    always_comb begin
        main_d       = main_f;
        skid_d       = skid_f;
        main_valid_d = main_valid;
        skid_valid_d = skid_valid;
        if (main_free) begin
            if (skid_valid) begin
                main_d       = skid_f;
                main_valid_d = 1'b1;
                skid_valid_d = accept;
                if (accept) begin
                    skid_d = in_f;
                end
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_d = in_f;
                end
            end
        end else if (accept) begin
            skid_d       = in_f;
            skid_valid_d = 1'b1;
        end
    end

    // State update; flush only drops valids, reset also zeroes the slot data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_valid <= main_valid_d;
            skid_valid <= skid_valid_d;
            in_ready_q <= !skid_valid_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = main_valid;
    assign out_alu_ctrl  = main_q.alu_ctrl;
    assign out_a         = main_q.a;
    assign out_b         = main_q.b;
    assign out_pc        = main_q.pc;
    assign out_rd        = main_q.rd;
    assign out_reg_write = main_q.reg_write;
    assign out_branch    = main_q.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a
// queue-based FIFO reference model (capacity 2, optional forwarding).
module tb_id_ex_stage;
    import id_ex_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n, flush, in_valid, in_ready;
    logic [2:0]      in_alu_ctrl;
    logic [XLEN-1:0] in_a, in_b, in_pc;
    logic [4:0]      in_rd, in_rs1, in_rs2;
    logic            in_use_rs1, in_use_rs2, in_reg_write, in_branch;
    logic            fwd_valid;
    logic [4:0]      fwd_rd;
    logic [XLEN-1:0] fwd_data;
    logic            out_valid, out_ready;
    logic [2:0]      out_alu_ctrl;
    logic [XLEN-1:0] out_a, out_b, out_pc;
    logic [4:0]      out_rd;
    logic            out_reg_write, out_branch;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_ctrl(in_alu_ctrl), .in_a(in_a), .in_b(in_b), .in_pc(in_pc),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_reg_write(in_reg_write), .in_branch(in_branch),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_ctrl(out_alu_ctrl), .out_a(out_a), .out_b(out_b), .out_pc(out_pc),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_branch(out_branch)
    );

    int           checks   = 0;
    int           failures = 0;
    id_ex_entry_t model_q[$];
    bit           zero_out = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Writeback bus rule: fwd_valid, nonzero rd, operand sourced from that register.
    function automatic id_ex_entry_t patch(input id_ex_entry_t e);
        id_ex_entry_t r;
        r = e;
`ifdef ID_EX_FWD_EN
        if (fwd_valid && fwd_rd != 5'd0 && e.use_rs1 && e.rs1 == fwd_rd) r.a = fwd_data;
        if (fwd_valid && fwd_rd != 5'd0 && e.use_rs2 && e.rs2 == fwd_rd) r.b = fwd_data;
`endif
        return r;
    endfunction

    task automatic model_step();
        id_ex_entry_t inc;
        bit           acc, cons;
        if (!rst_n) begin
            model_q.delete();
            zero_out = 1'b1;
        end else if (flush) begin
            model_q.delete();
        end else begin
            acc  = in_valid && (model_q.size() < 2);
            cons = (model_q.size() > 0) && out_ready;
            foreach (model_q[i]) model_q[i] = patch(model_q[i]);
            if (cons) void'(model_q.pop_front());
            if (acc) begin
                inc.alu_ctrl  = in_alu_ctrl;
                inc.a         = in_a;
                inc.b         = in_b;
                inc.pc        = in_pc;
                inc.rd        = in_rd;
                inc.rs1       = in_rs1;
                inc.rs2       = in_rs2;
                inc.use_rs1   = in_use_rs1;
                inc.use_rs2   = in_use_rs2;
                inc.reg_write = in_reg_write;
                inc.branch    = in_branch;
                model_q.push_back(patch(inc));
                zero_out = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        check_eq("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
        check_eq("in_ready", 32'(in_ready), 32'(model_q.size() < 2));
        if (model_q.size() > 0) begin
            check_eq("out_a", out_a, model_q[0].a);
            check_eq("out_b", out_b, model_q[0].b);
            check_eq("out_pc", out_pc, model_q[0].pc);
            check_eq("out_alu_ctrl", 32'(out_alu_ctrl), 32'(model_q[0].alu_ctrl));
            check_eq("out_rd", 32'(out_rd), 32'(model_q[0].rd));
            check_eq("out_flags", 32'({out_reg_write, out_branch}),
                     32'({model_q[0].reg_write, model_q[0].branch}));
        end else if (zero_out) begin
            check_eq("reset_out_a", out_a, 32'h0);
            check_eq("reset_out_pc", out_pc, 32'h0);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_alu_ctrl = 3'b000; in_a = '0; in_b = '0; in_pc = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_use_rs1 = 1'b0; in_use_rs2 = 1'b0; in_reg_write = 1'b0; in_branch = 1'b0;
        fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;
    endtask

    task automatic offer(input logic [31:0] a);
        in_valid = 1'b1; in_a = a; in_b = a ^ 32'hFFFF_0000; in_pc = a << 2;
        in_rd = 5'(a); in_alu_ctrl = ALU_ADD;
    endtask

    logic [31:0] exp_fwd;

    initial begin
        idle();

        // Reset held 2 cycles while decode offers an entry.
        rst_n = 1'b0; offer(32'h55);
        cycle(); cycle();
        check_eq("rst_out_valid", 32'(out_valid), 32'h0);
        check_eq("rst_in_ready", 32'(in_ready), 32'h1);
        check_eq("rst_out_a", out_a, 32'h0);
        rst_n = 1'b1; offer(32'h77);
        cycle();
        in_valid = 1'b0;
        check_eq("lat1_valid", 32'(out_valid), 32'h1);
        check_eq("lat1_a", out_a, 32'h77);

        // Streaming, one per cycle with out_ready high.
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            offer(32'(k));
            cycle();
            check_eq("stream_a", out_a, 32'(k));
        end
        in_valid = 1'b0;
        cycle();
        check_eq("stream_drained", 32'(out_valid), 32'h0);

        // Backpressure: two accepts fill both slots.
        out_ready = 1'b0;
        offer(32'hA); cycle();
        offer(32'hB); cycle();
        in_valid = 1'b0;
        check_eq("bp_in_ready_low", 32'(in_ready), 32'h0);
        check_eq("bp_hold_a", out_a, 32'hA);
        cycle();
        check_eq("bp_still_a", out_a, 32'hA);
        out_ready = 1'b1; cycle();
        check_eq("bp_then_b", out_a, 32'hB);
        check_eq("bp_ready_back", 32'(in_ready), 32'h1);
        cycle();
        check_eq("bp_empty", 32'(out_valid), 32'h0);

        // Flush with both slots full and a new entry offered.
        out_ready = 1'b0;
        offer(32'h1A); cycle();
        offer(32'h1B); cycle();
        offer(32'h1C); flush = 1'b1; cycle();
        check_eq("flush_valid", 32'(out_valid), 32'h0);
        check_eq("flush_ready", 32'(in_ready), 32'h1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cycle();
        check_eq("flush_no_ghost", 32'(out_valid), 32'h0);

        // Forwarding onto a resident entry under backpressure.
`ifdef ID_EX_FWD_EN
        exp_fwd = 32'hDEAD;
`else
        exp_fwd = 32'h11;
`endif
        out_ready = 1'b0;
        offer(32'h11); in_rs1 = 5'd5; in_use_rs1 = 1'b1; cycle();
        in_valid = 1'b0;
        check_eq("fwd_pre", out_a, 32'h11);
        fwd_valid = 1'b1; fwd_rd = 5'd5; fwd_data = 32'hDEAD; cycle();
        check_eq("fwd_hit", out_a, exp_fwd);
        fwd_valid = 1'b0; flush = 1'b1; cycle();
        flush = 1'b0;
        offer(32'h11); in_rs1 = 5'd5; in_use_rs1 = 1'b1; cycle();
        in_valid = 1'b0;
        fwd_valid = 1'b1; fwd_rd = 5'd0; fwd_data = 32'hDEAD; cycle();
        check_eq("fwd_rd_zero", out_a, 32'h11);
        idle();
        cycle();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            rst_n        = ($urandom % 250) != 0;
            flush        = ($urandom % 25) == 0;
            in_valid     = ($urandom % 4) != 0;
            out_ready    = ($urandom % 3) != 0;
            in_alu_ctrl  = 3'($urandom);
            in_a         = $urandom;
            in_b         = $urandom;
            in_pc        = $urandom;
            in_rd        = 5'($urandom);
            in_rs1       = 5'($urandom_range(0, 7));
            in_rs2       = 5'($urandom_range(0, 7));
            in_use_rs1   = 1'($urandom);
            in_use_rs2   = 1'($urandom);
            in_reg_write = 1'($urandom);
            in_branch    = 1'($urandom);
            fwd_valid    = 1'($urandom);
            fwd_rd       = 5'($urandom_range(0, 7));
            fwd_data     = $urandom;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the RISC-V core, sitting directly upstream of the ALU. It captures decoded operands, ALU control and writeback tags from decode. It presents them to the execute stage behind a valid/ready handshake, using a 2-entry skid buffer so that ready is fully registered. Optional operand forwarding patches stale register operands from the writeback bus while entries wait.

## Interface
- XLEN, 32, operand and PC width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  drop all resident entries (branch taken)
- in_valid  in  1  decode offers an entry
- in_ready  out  1  stage can accept; registered
- in_alu_ctrl  in  3  000 add, 001 sub, 010 and, 011 or, 101 slt; other codes passed through unchanged
- in_a, in_b  in  XLEN  operands
- in_pc  in  XLEN  instruction PC
- in_rd, in_rs1, in_rs2  in  5  register indices
- in_use_rs1, in_use_rs2  in  1  a / b came from rs1 / rs2 (b=0 means immediate)
- in_reg_write, in_branch  in  1  control flags
- fwd_valid  in  1  writeback bus valid
- fwd_rd  in  5  writeback destination
- fwd_data  in  XLEN  writeback value
- out_valid  out  1  entry presented to ALU
- out_ready  in  1  execute consumes entry
- out_alu_ctrl, out_a, out_b, out_pc, out_rd, out_reg_write, out_branch  out  as inputs  presented entry

## Operation
- Two slots: main (drives out_*) and skid. Each slot holds all in_* fields plus a valid bit.
- Accept when in_valid && in_ready.
- Accepted entry goes to main if main is empty or being consumed this cycle (out_ready). Otherwise it goes to skid.
- When main is consumed and skid is valid, skid moves to main. A same-cycle accept then lands in skid.
- in_ready = !skid_valid, taken from a register.
- Ordering is strict FIFO. No entry is duplicated or lost except on flush.
- Flush: both valids clear next cycle. A same-cycle accept is discarded. Flush has priority over accept and consume.
- Reset (rst_n=0 at clock edge): both valids = 0, in_ready = 1, all out_* data = 0. Reset mid-transfer discards entries.
- Entries are held stable while out_valid && !out_ready.
- No arithmetic is done on operands. alu_ctrl is not validated.

## Timing
- Latency: 1 cycle from accept to out_valid (empty stage).
- Throughput: 1 entry/cycle while out_ready stays high.
- With out_ready low: accepts 2 entries, then in_ready drops in the cycle after the second accept.
- in_ready rises the cycle after main is consumed, once skid has moved to main.
- No combinational path from out_ready to in_ready.

## Configuration
- ID_EX_FWD_EN defined: forwarding applies each cycle to the incoming entry and to both resident slots.
- Forwarding condition: fwd_valid && fwd_rd != 0 && use_rsN && rsN == fwd_rd. The a or b field is then replaced by fwd_data.
- A forwarded value is visible on out_* one cycle after the fwd cycle if the entry is resident, or with the capture if the entry arrives that cycle.
- ID_EX_FWD_EN undefined: fwd_* and in_use_rs*/in_rs* are ignored, and operands are stored verbatim.

## Structure
- Package id_ex_pkg holds:
  - ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101
  - the id_ex_entry_t struct (all slot fields)
  - REG_ZERO=5'd0
- Sub-module id_ex_fwd_mux, combinational: takes one entry plus the fwd bus and returns the patched entry. It is instantiated three times (incoming, main, skid) under ID_EX_FWD_EN.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, out_a=0. First accept after release gives out_valid one cycle later.
- Streaming: 8 entries, a=k, alu_ctrl=000, out_ready=1 -> one output per cycle, in order, latency 1.
- Backpressure: out_ready=0 with entries A, B offered -> in_ready=0 after B; out holds A. Raise out_ready -> A, then B, then in_ready=1.
- Flush with in_valid and both slots full -> next cycle out_valid=0, in_ready=1; the flushed-cycle input never appears.
- Forwarding (ID_EX_FWD_EN): entry rs1=5, use_rs1=1, a=0x11 held under backpressure; fwd rd=5, data=0xDEAD -> out_a=0xDEAD next cycle. Same stimulus with fwd_rd=0 -> out_a stays 0x11.
- Without the macro, the same forwarding stimulus -> out_a=0x11 unchanged.
